// File: rtl/line_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_scheduler
// Purpose  : Steers incoming words into four rotating line buffers and reads
//            3x3 windows from the three oldest complete lines.
// Options  : define LB_SCHED_OVERFLOW_EN for a sticky dropped-word flag.
// Revision : 1.0
// ============================================================================
module line_buffer_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int IMAGE_WIDTH = 324
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pixel_valid,
  output logic        o_pixel_ready,
  output logic [3:0]  o_lb_wr_valid,
  output logic [3:0]  o_lb_rd,
  input  logic [95:0] i_lb_pixels,
  output logic [71:0] o_window,
  output logic        o_window_valid,
  input  logic        i_window_ready,
  output logic        o_line_done,
  output logic        o_overflow
);

  localparam int c_WORDS  = IMAGE_WIDTH / (DATA_WIDTH / 8);
  localparam int c_WCNT_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_WCNT_W-1:0] r_wr_cnt;
  logic [8:0]          r_col;
  logic [1:0]          r_wr_sel;
  logic [1:0]          r_rd_sel;
  logic [2:0]          r_fill;
  logic [2:0]          w_fill_next;
  logic                r_line_done;

  logic                w_pixel_ready;
  logic                w_wr_accept;
  logic                w_wr_line_end;
  logic                w_rd_xfer;
  logic                w_rd_line_end;
  logic [1:0]          w_rd_sel1;
  logic [1:0]          w_rd_sel2;
  logic [3:0]          w_lb_rd;
  logic [23:0]         w_taps [4];

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_taps
      assign w_taps[n] = i_lb_pixels[24*n +: 24];
    end
  endgenerate

  assign w_rd_sel1 = r_rd_sel + 2'd1;
  assign w_rd_sel2 = r_rd_sel + 2'd2;

  assign w_pixel_ready = !i_reset && (r_fill < 3'd4);
  assign w_wr_accept   = i_pixel_valid && w_pixel_ready;
  assign w_wr_line_end = w_wr_accept && (r_wr_cnt == c_WCNT_W'(c_WORDS - 1));
  assign w_rd_xfer     = !i_reset && (r_state == READ) && i_window_ready;
  assign w_rd_line_end = w_rd_xfer && (r_col == 9'(IMAGE_WIDTH - 1));

  // A line finishing on each side in the same cycle leaves occupancy unchanged
  always_comb begin
    w_fill_next = r_fill;
    if (w_wr_line_end && !w_rd_line_end) begin
      w_fill_next = r_fill + 3'd1;
    end else if (!w_wr_line_end && w_rd_line_end) begin
      w_fill_next = r_fill - 3'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_fill_next >= 3'd3) w_state_next = READ;
      READ:    if (w_rd_line_end && (w_fill_next < 3'd3)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_lb_rd = 4'b0000;
    if (w_rd_xfer) begin
      w_lb_rd[r_rd_sel]  = 1'b1;
      w_lb_rd[w_rd_sel1] = 1'b1;
      w_lb_rd[w_rd_sel2] = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_wr_cnt    <= '0;
      r_col       <= '0;
      r_wr_sel    <= 2'd0;
      r_rd_sel    <= 2'd0;
      r_fill      <= 3'd0;
      r_line_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_fill      <= w_fill_next;
      r_line_done <= w_rd_line_end;
      if (w_wr_accept) begin
        if (w_wr_line_end) begin
          r_wr_cnt <= '0;
          r_wr_sel <= r_wr_sel + 2'd1;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      if (w_rd_xfer) begin
        if (w_rd_line_end) begin
          r_col    <= '0;
          r_rd_sel <= r_rd_sel + 2'd1;
        end else begin
          r_col <= r_col + 9'd1;
        end
      end
    end
  end

`ifdef LB_SCHED_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (i_pixel_valid && !w_pixel_ready) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_pixel_ready  = w_pixel_ready;
  assign o_lb_wr_valid  = w_wr_accept ? (4'b0001 << r_wr_sel) : 4'b0000;
  assign o_lb_rd        = w_lb_rd;
  assign o_window_valid = !i_reset && (r_state == READ);
  assign o_window       = {w_taps[w_rd_sel2], w_taps[w_rd_sel1], w_taps[r_rd_sel]};
  assign o_line_done    = r_line_done;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buffer_scheduler
// Purpose  : Directed self-checking bench for line_buffer_scheduler.
// Revision : 1.0
// ============================================================================
module tb_line_buffer_scheduler;

  localparam logic [23:0] c_B0 = 24'hA0A0A0;
  localparam logic [23:0] c_B1 = 24'hB1B1B1;
  localparam logic [23:0] c_B2 = 24'hC2C2C2;
  localparam logic [23:0] c_B3 = 24'hD3D3D3;

  logic        i_clock;
  logic        i_reset;
  logic        i_pixel_valid;
  logic        o_pixel_ready;
  logic [3:0]  o_lb_wr_valid;
  logic [3:0]  o_lb_rd;
  logic [95:0] i_lb_pixels;
  logic [71:0] o_window;
  logic        o_window_valid;
  logic        i_window_ready;
  logic        o_line_done;
  logic        o_overflow;

  int total;
  int bad;

  line_buffer_scheduler #(
    .DATA_WIDTH (32),
    .IMAGE_WIDTH(324)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_pixel_valid (i_pixel_valid),
    .o_pixel_ready (o_pixel_ready),
    .o_lb_wr_valid (o_lb_wr_valid),
    .o_lb_rd       (o_lb_rd),
    .i_lb_pixels   (i_lb_pixels),
    .o_window      (o_window),
    .o_window_valid(o_window_valid),
    .i_window_ready(i_window_ready),
    .o_line_done   (o_line_done),
    .o_overflow    (o_overflow)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check_value(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    logic [3:0] rd_pat [4];
    logic       ovf_exp;
    int         ld_count;

    total = 0;
    bad   = 0;
`ifdef LB_SCHED_OVERFLOW_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    // read strobes for rd_sel = 1, 2, 3, 0 in the streaming test
    rd_pat[0] = 4'b1110;
    rd_pat[1] = 4'b1101;
    rd_pat[2] = 4'b1011;
    rd_pat[3] = 4'b0111;

    i_lb_pixels    = {c_B3, c_B2, c_B1, c_B0};
    i_reset        = 1'b1;
    i_pixel_valid  = 1'b1;
    i_window_ready = 1'b1;
    #1;
    check_value("rst_ready_forced", 96'(o_pixel_ready), 96'd0);
    check_value("rst_wr_forced", 96'(o_lb_wr_valid), 96'd0);
    step();
    step();
    check_value("rst_line_done", 96'(o_line_done), 96'd0);
    check_value("rst_overflow", 96'(o_overflow), 96'd0);
    i_reset        = 1'b0;
    i_pixel_valid  = 1'b0;
    i_window_ready = 1'b0;
    #1;
    check_value("post_rst_ready", 96'(o_pixel_ready), 96'd1);
    check_value("post_rst_wvalid", 96'(o_window_valid), 96'd0);
    check_value("post_rst_wr", 96'(o_lb_wr_valid), 96'd0);
    check_value("post_rst_rd", 96'(o_lb_rd), 96'd0);

    // fill three lines with no downstream consumer
    for (int k = 0; k < 243; k++) begin
      i_pixel_valid = 1'b1;
      #1;
      check_value("fill_wr", 96'(o_lb_wr_valid), 96'(4'b0001 << (k / 81)));
      check_value("fill_wvalid", 96'(o_window_valid), 96'd0);
      step();
    end
    i_pixel_valid = 1'b0;
    #1;
    check_value("fill_wvalid_on", 96'(o_window_valid), 96'd1);
    check_value("fill_ready", 96'(o_pixel_ready), 96'd1);
    check_value("fill_rd_stalled", 96'(o_lb_rd), 96'd0);
    check_value("fill_window", 96'(o_window), 96'({c_B2, c_B1, c_B0}));

    // drain one line
    ld_count = 0;
    i_window_ready = 1'b1;
    for (int c = 0; c < 324; c++) begin
      #1;
      check_value("drain_rd", 96'(o_lb_rd), 96'(4'b0111));
      check_value("drain_wvalid", 96'(o_window_valid), 96'd1);
      step();
      if (o_line_done) ld_count++;
    end
    check_value("drain_idle", 96'(o_window_valid), 96'd0);
    check_value("drain_rd_idle", 96'(o_lb_rd), 96'd0);
    step();
    check_value("drain_done_pulse", 96'(o_line_done), 96'd0);
    check_value("drain_done_count", 96'(ld_count), 96'd1);

    // leave a partial line, then reset mid-line
    i_window_ready = 1'b0;
    i_pixel_valid  = 1'b1;
    for (int k = 0; k < 40; k++) step();
    i_reset = 1'b1;
    #1;
    check_value("midrst_wr_forced", 96'(o_lb_wr_valid), 96'd0);
    check_value("midrst_wvalid", 96'(o_window_valid), 96'd0);
    step();
    i_reset = 1'b0;
    i_pixel_valid = 1'b0;
    #1;

    // fill all four buffers, then push one word too many
    for (int k = 0; k < 324; k++) begin
      i_pixel_valid = 1'b1;
      #1;
      check_value("full_ready", 96'(o_pixel_ready), 96'd1);
      check_value("full_wr", 96'(o_lb_wr_valid), 96'(4'b0001 << (k / 81)));
      step();
    end
    #1;
    check_value("full_not_ready", 96'(o_pixel_ready), 96'd0);
    check_value("drop_wr", 96'(o_lb_wr_valid), 96'd0);
    check_value("drop_rd", 96'(o_lb_rd), 96'd0);
    step();
    i_pixel_valid = 1'b0;
    #1;
    check_value("overflow", 96'(o_overflow), 96'(ovf_exp));
    check_value("still_full", 96'(o_pixel_ready), 96'd0);
    step();
    check_value("overflow_hold", 96'(o_overflow), 96'(ovf_exp));

    // drain one line: fill 4 -> 3 and reading continues
    i_window_ready = 1'b1;
    for (int c = 0; c < 324; c++) step();
    i_window_ready = 1'b0;
    #1;
    check_value("full_drain_done", 96'(o_line_done), 96'd1);
    check_value("full_drain_wvalid", 96'(o_window_valid), 96'd1);
    check_value("full_drain_ready", 96'(o_pixel_ready), 96'd1);

    // write end coincides with read end on every line
    i_window_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 324; c++) begin
        i_pixel_valid = (c >= 243);
        #1;
        check_value("sim_rd", 96'(o_lb_rd), 96'(rd_pat[l]));
        if (c == 243) check_value("sim_wr", 96'(o_lb_wr_valid), 96'(4'b0001 << l));
        if (l == 1 && c == 0) check_value("sim_window_sel2", 96'(o_window), 96'({c_B0, c_B3, c_B2}));
        step();
      end
      i_pixel_valid = 1'b0;
      #1;
      check_value("sim_line_done", 96'(o_line_done), 96'd1);
      check_value("sim_wvalid", 96'(o_window_valid), 96'd1);
      check_value("sim_ready", 96'(o_pixel_ready), 96'd1);
    end
    #1;
    check_value("wrap_rd", 96'(o_lb_rd), 96'(4'b1110));
    check_value("wrap_window", 96'(o_window), 96'({c_B3, c_B2, c_B1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
